data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe.sv | 126 ++++++++++++
 tb/tb_data_mem_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Single-port data memory with a fixed per-access latency, a one-deep request latch and Done/Err pulses.
// Optional macro DATA_MEM_PIPE_CLEAR_EN adds a post-reset sweep that zeroes every word.
module data_mem_pipe #(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [AW-1:0] DataAddress,
    input  logic          ReadMem,
    input  logic          WriteMem,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

`ifdef DATA_MEM_PIPE_CLEAR_EN
    typedef enum logic [1:0] {IDLE, WAIT, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`else
    typedef enum logic {IDLE, WAIT} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          write_q;
    logic          in_range;
    logic          complete;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
`ifdef DATA_MEM_PIPE_CLEAR_EN
    logic [AW-1:0] clr_addr;
`endif

    logic [DW-1:0] mem [DEPTH];

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign complete = (state == WAIT) && (cnt == 4'd0);
    assign Busy     = (state != IDLE);

    // The array has a single write port shared by normal writes and the clear sweep.
    always_comb begin
        mem_we = complete && write_q && in_range;
        mem_wa = addr_q;
        mem_wd = data_q;
`ifdef DATA_MEM_PIPE_CLEAR_EN
        if (state == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_addr;
            mem_wd = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RESET_STATE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            DataOut <= '0;
            Done    <= 1'b0;
            Err     <= 1'b0;
`ifdef DATA_MEM_PIPE_CLEAR_EN
            clr_addr <= '0;
`endif
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A simultaneous read and write collapses into a write.
                    if (ReadMem || WriteMem) begin
                        addr_q  <= DataAddress;
                        data_q  <= DataIn;
                        write_q <= WriteMem;
                        cnt     <= LAT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        Done  <= 1'b1;
                        Err   <= !in_range;
                        state <= IDLE;
                        if (!write_q) begin
                            DataOut <= in_range ? mem[addr_q] : '0;
                        end
                    end
                end
`ifdef DATA_MEM_PIPE_CLEAR_EN
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe: dut_a (LATENCY=1, DEPTH=200) and dut_b (LATENCY=3, DEPTH=16).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and checks them on every Done.
module tb_data_mem_pipe;

`ifdef DATA_MEM_PIPE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] dout;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    logic       rstn [2];
    logic       rd   [2];
    logic       wr   [2];
    logic [7:0] addr [2];
    logic [7:0] din  [2];
    logic [7:0] dout [2];
    logic       busy [2];
    logic       done [2];
    logic       err  [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_pipe #(.DW(8), .AW(8), .DEPTH(200), .LATENCY(1)) dut_a (
        .CLK(clk), .reset_n(rstn[0]), .DataAddress(addr[0]), .ReadMem(rd[0]),
        .WriteMem(wr[0]), .DataIn(din[0]), .DataOut(dout[0]), .Busy(busy[0]),
        .Done(done[0]), .Err(err[0])
    );

    data_mem_pipe #(.DW(8), .AW(8), .DEPTH(16), .LATENCY(3)) dut_b (
        .CLK(clk), .reset_n(rstn[1]), .DataAddress(addr[1]), .ReadMem(rd[1]),
        .WriteMem(wr[1]), .DataIn(din[1]), .DataOut(dout[1]), .Busy(busy[1]),
        .Done(done[1]), .Err(err[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic monitorPop(input int w);
        exp_t e;
        if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
            checkOutput($sformatf("unexpected_done_dut%0d", w), 1, 0);
            return;
        end
        if (w == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        checkOutput($sformatf("done_cycle_dut%0d", w), cyc, e.cyc);
        checkOutput($sformatf("dataout_dut%0d", w), dout[w], e.dout);
        checkOutput($sformatf("err_dut%0d", w), err[w], e.err);
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (rstn[w] === 1'b1 && done[w] === 1'b1) monitorPop(w);
            if (err[w] === 1'b1 && done[w] !== 1'b1)
                checkOutput($sformatf("err_without_done_dut%0d", w), 1, 0);
        end
    end

    task automatic waitIdle(input int w);
        int n = 0;
        while (busy[w] !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) checkOutput($sformatf("timeout_idle_dut%0d", w), 1, 0);
    endtask

    // Issue one request from a negedge; poke re-drives a write while the access is in flight.
    task automatic applyStimulus(input int w, input bit r, input bit wv, input logic [7:0] a,
                                 input logic [7:0] d, input logic [7:0] exp_dout,
                                 input bit exp_err, input bit poke);
        exp_t e;
        int   lat;
        lat = (w == 0) ? 1 : 3;
        waitIdle(w);
        rd[w] = r;
        wr[w] = wv;
        addr[w] = a;
        din[w] = d;
        e.cyc  = cyc + 1 + lat + 1;
        e.dout = exp_dout;
        e.err  = exp_err;
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        if (poke) begin
            rd[w] = 1'b0;
            wr[w] = 1'b1;
            din[w] = ~d;
            @(negedge clk);
        end
        rd[w] = 1'b0;
        wr[w] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   bc;
        int   dc;
        int   a0;
        exp_t e;

        for (int w = 0; w < 2; w++) begin
            rstn[w] = 1'b0;
            rd[w] = 1'b0;
            wr[w] = 1'b0;
            addr[w] = 8'h00;
            din[w] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            checkOutput($sformatf("reset_dataout_dut%0d", w), dout[w], 0);
            checkOutput($sformatf("reset_done_dut%0d", w), done[w], 0);
            checkOutput($sformatf("reset_err_dut%0d", w), err[w], 0);
            checkOutput($sformatf("reset_busy_dut%0d", w), busy[w], CLR);
        end
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;

        bc = 0;
        #1;
        if (busy[1] === 1'b1) bc++;
        repeat (40) begin
            @(negedge clk);
            if (busy[1] === 1'b1) bc++;
        end
        checkOutput("clear_busy_cycles", bc, CLR ? 16 : 0);

`ifdef DATA_MEM_PIPE_CLEAR_EN
        for (int i = 0; i < 16; i++) applyStimulus(1, 1'b1, 1'b0, 8'(i), 8'h00, 8'h00, 1'b0, 1'b0);
`endif

        // dut_a: basic write/read, out-of-range, read+write collision, ignored requests while busy
        applyStimulus(0, 1'b0, 1'b1, 8'd3,   8'hA5, 8'h00, 1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 8'd82,  8'h5A, 8'hA5, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 8'd210, 8'h11, 8'hA5, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 8'd210, 8'h00, 8'h00, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 8'd82,  8'h00, 8'h5A, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b1, 8'd5,   8'h3C, 8'h5A, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 8'd5,   8'h00, 8'h3C, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1, 8'd7,   8'h42, 8'h3C, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 8'd255, 8'h00, 8'h00, 1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 1'b0);

        // dut_b: ReadMem held across three back-to-back accesses
        applyStimulus(1, 1'b0, 1'b1, 8'd2, 8'h77, 8'h00, 1'b0, 1'b0);
        waitIdle(1);
        rd[1] = 1'b1;
        addr[1] = 8'd2;
        a0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.cyc  = a0 + 4 + 5 * k;
            e.dout = 8'h77;
            e.err  = 1'b0;
            q1.push_back(e);
        end
        bc = 0;
        dc = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy[1] === 1'b1) bc++;
            if (done[1] === 1'b1) dc++;
        end
        rd[1] = 1'b0;
        checkOutput("held_read_busy_cycles", bc, 12);
        checkOutput("held_read_done_count", dc, 3);
        applyStimulus(1, 1'b0, 1'b1, 8'd9, 8'h99, 8'h77, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 8'd9, 8'h00, 8'h99, 1'b0, 1'b0);

        // dut_a: reset pulse while a write of FF to address 7 is waiting
        waitIdle(0);
        wr[0] = 1'b1;
        addr[0] = 8'd7;
        din[0] = 8'hFF;
        @(negedge clk);
        wr[0] = 1'b0;
        checkOutput("busy_in_wait", busy[0], 1);
        rstn[0] = 1'b0;
        #1;
        checkOutput("abort_dataout", dout[0], 0);
        checkOutput("abort_busy", busy[0], CLR);
        checkOutput("abort_done", done[0], 0);
        @(negedge clk);
        rstn[0] = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 8'd7, 8'h00, CLR ? 8'h00 : 8'h42, 1'b0, 1'b0);

        waitIdle(0);
        waitIdle(1);
        repeat (4) @(negedge clk);
        checkOutput("pending_dut0", q0.size(), 0);
        checkOutput("pending_dut1", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
